// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: run request, sample input stream, result output.
interface sum_accumulator_if #(
  parameter int IN_W    = 9,
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 8
);
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ovf;
  logic               busy;

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating accumulator over a programmed number of adder sums; result held
// on a valid/ready output until taken.
module sum_accumulator #(
  parameter int IN_W    = 9,
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [COUNT_W-1:0] r_rem, w_rem_nxt;

  logic               w_beat;
  logic [ACC_W:0]     w_sum;

  assign w_beat = bus.in_valid && (r_state == S_ACCUM);
  // One extra bit so the carry out of the accumulator is the overflow test.
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_acc_nxt = '0;
          w_ovf_nxt = 1'b0;
          if (bus.len != '0) begin
            w_rem_nxt   = bus.len;
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_ACCUM: begin
        if (w_beat) begin
          w_rem_nxt = r_rem - 1'b1;
          // Once saturated the total is pinned for the rest of the run.
          if (r_ovf || w_sum[ACC_W]) begin
            w_acc_nxt = '1;
            w_ovf_nxt = 1'b1;
          end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
          end
          if (r_rem == COUNT_W'(1)) w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_sum   = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Scenario bench for sum_accumulator: expected results queued at stimulus time,
// compared when the block presents them.
module tb_sum_accumulator;
  localparam int IN_W = 9, ACC_W = 16, COUNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) bus ();

  sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   m_total;

  task automatic do_start(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = COUNT_W'(l);
    m_total   = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Drive one beat, then idle for gap cycles while checking in_ready stays up.
  task automatic send_beat(input int d, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    m_total += d;
    for (int g = 0; g < gap; g++) begin
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_in_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.sum = (m_total > 65535) ? 16'hFFFF : m_total[15:0];
    e.ovf = (m_total > 65535);
    sb.push_back(e);
  endtask

  // Wait for a result, compare against the scoreboard, optionally backpressure.
  task automatic collect(input string name, input int hold, output int waited);
    exp_t e;
    logic [ACC_W-1:0] s0;
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles want 1", name, bus.out_valid, waited);
      return;
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: out_sum=%0d with empty scoreboard", name, bus.out_sum);
      return;
    end
    e = sb.pop_front();
    n_chk++;
    if (bus.out_sum !== e.sum || bus.out_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s_result: got sum=%0d ovf=%b want sum=%0d ovf=%b",
               name, bus.out_sum, bus.out_ovf, e.sum, e.ovf);
    end
    s0 = bus.out_sum;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== s0 || bus.out_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL %s_hold: got valid=%b sum=%0d ovf=%b want valid=1 sum=%0d ovf=%b",
                 name, bus.out_valid, bus.out_sum, bus.out_ovf, s0, e.ovf);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: got valid=%b busy=%b in_ready=%b want 0 0 0",
               name, bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 11; c++) begin
      n_chk++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
          bus.out_ovf !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
                 c, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    int w;
    do_start(3);
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accum: in_ready=%b busy=%b want 1 1", bus.in_ready, bus.busy);
    end
    send_beat(2, 0);
    send_beat(5, 0);
    send_beat(255, 0);
    push_expected();
    collect("basic", 0, w);
    n_chk++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL basic_latency: waited %0d extra cycles want 0", w);
    end
  endtask

  task automatic test_stalls();
    int w;
    do_start(4);
    send_beat(510, 2);
    send_beat(1, 2);
    send_beat(0, 2);
    send_beat(85, 0);
    push_expected();
    collect("stall", 5, w);
  endtask

  task automatic test_saturation();
    int w;
    do_start(129);
    for (int i = 0; i < 129; i++) send_beat(510, 0);
    push_expected();
    collect("sat", 0, w);
    do_start(1);
    send_beat(7, 0);
    push_expected();
    collect("sat_clear", 0, w);
  endtask

  task automatic test_zero_len();
    int w;
    do_start(0);
    push_expected();
    collect("zero_len", 0, w);
    n_chk++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL zero_len_latency: waited %0d extra cycles want 0", w);
    end
    do_start(2);
    send_beat(40, 0);
    bus.start = 1'b1;
    bus.len   = COUNT_W'(9);
    @(negedge clk);
    bus.start = 1'b0;
    send_beat(60, 0);
    push_expected();
    collect("ignored_start", 0, w);
    n_chk++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL ignored_start_len: waited %0d extra cycles want 0", w);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_start(5);
    for (int i = 0; i < 3; i++) send_beat(100, 0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
        bus.out_ovf !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.out_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b sum=%0d want 0 0", bus.busy, bus.out_sum);
    end
    do_start(1);
    send_beat(9, 0);
    push_expected();
    collect("after_reset", 0, w);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stalls();
    test_saturation();
    test_zero_len();
    test_reset_mid();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
